// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with a ready/valid handshake and a one-entry skid buffer.
// Carries PC, instruction and control bits; supports flush, hazard stall and a stall counter.
module pipe_stage_skid #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     IR_W     = 32,
    parameter int unsigned     CTRL_W   = 8,
    parameter logic [IR_W-1:0] NOP_IR   = 32'h83FFF800,
    parameter logic [PC_W-1:0] RESET_PC = 32'h00000000,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [IR_W-1:0]   in_ir,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [IR_W-1:0]   out_ir,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    logic              m_valid_r, m_valid_s;
    logic [PC_W-1:0]   m_pc_r, m_pc_s;
    logic [IR_W-1:0]   m_ir_r, m_ir_s;
    logic [CTRL_W-1:0] m_ctrl_r, m_ctrl_s;
    logic              s_valid_r, s_valid_s;
    logic [PC_W-1:0]   s_pc_r, s_pc_s;
    logic [IR_W-1:0]   s_ir_r, s_ir_s;
    logic [CTRL_W-1:0] s_ctrl_r, s_ctrl_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              in_fire_s;
    logic              take_s;

    // in_ready is the inverted skid valid flop, so it never depends on out_ready or stall
    assign in_ready  = ~s_valid_r;
    assign in_fire_s = in_valid & ~s_valid_r;
    assign take_s    = m_valid_r & out_ready & ~stall;

    assign out_valid = m_valid_r;
    assign out_pc    = m_pc_r;
    assign out_ir    = m_ir_r;
    assign out_ctrl  = m_ctrl_r;
    assign stall_cnt = cnt_r;

    // Next-state for main and skid registers: flush first, then refill M from S before new input
    always_comb begin
        m_valid_s = m_valid_r;
        m_pc_s    = m_pc_r;
        m_ir_s    = m_ir_r;
        m_ctrl_s  = m_ctrl_r;
        s_valid_s = s_valid_r;
        s_pc_s    = s_pc_r;
        s_ir_s    = s_ir_r;
        s_ctrl_s  = s_ctrl_r;
        if (flush) begin
            m_valid_s = 1'b0;
            s_valid_s = 1'b0;
            m_ir_s    = NOP_IR;
            m_ctrl_s  = {CTRL_W{1'b0}};
        end else if (!m_valid_r || take_s) begin
            if (s_valid_r) begin
                m_valid_s = 1'b1;
                m_pc_s    = s_pc_r;
                m_ir_s    = s_ir_r;
                m_ctrl_s  = s_ctrl_r;
                s_valid_s = 1'b0;
            end else if (in_fire_s) begin
                m_valid_s = 1'b1;
                m_pc_s    = in_pc;
                m_ir_s    = in_ir;
                m_ctrl_s  = in_ctrl;
            end else begin
                m_valid_s = 1'b0;
            end
        end else if (in_fire_s) begin
            s_valid_s = 1'b1;
            s_pc_s    = in_pc;
            s_ir_s    = in_ir;
            s_ctrl_s  = in_ctrl;
        end else begin
            s_valid_s = s_valid_r;
        end
    end

    // Saturating stall counter; clear beats increment, flush leaves it alone
    always_comb begin
        cnt_s = cnt_r;
        if (clr_cnt) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (m_valid_r && stall && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r <= 1'b0;
            m_pc_r    <= RESET_PC;
            m_ir_r    <= NOP_IR;
            m_ctrl_r  <= {CTRL_W{1'b0}};
            s_valid_r <= 1'b0;
            s_pc_r    <= {PC_W{1'b0}};
            s_ir_r    <= {IR_W{1'b0}};
            s_ctrl_r  <= {CTRL_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            m_valid_r <= m_valid_s;
            m_pc_r    <= m_pc_s;
            m_ir_r    <= m_ir_s;
            m_ctrl_r  <= m_ctrl_s;
            s_valid_r <= s_valid_s;
            s_pc_r    <= s_pc_s;
            s_ir_r    <= s_ir_s;
            s_ctrl_r  <= s_ctrl_s;
            cnt_r     <= cnt_s;
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, clocked successor to the combinational IF/ID latch.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM) of the pipelined Beta core and carries four fields: PC, instruction, control bits and a valid flag.
- Adds a ready/valid handshake with a one-entry skid buffer, so upstream never sees a combinational ready path.
- Adds flush (bubble injection), a hazard stall input and a saturating stall-cycle counter.

Parameters:
- PC_W, 32, PC field width.
- IR_W, 32, instruction field width.
- CTRL_W, 8, packed control-bit width (RA2SEL, ASEL, BSEL, etc.).
- NOP_IR, 32'h83FFF800, instruction injected on reset/flush (ADD R31,R31,R31).
- RESET_PC, 32'h00000000, PC value held after reset.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat (registered).
- in_pc  in  PC_W  upstream PC.
- in_ir  in  IR_W  upstream instruction.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  registered PC.
- out_ir  out  IR_W  registered instruction.
- out_ctrl  out  CTRL_W  registered control bits.
- stall  in  1  hazard hold; blocks downstream transfer.
- flush  in  1  synchronous kill of all held beats.
- stall_cnt  out  CNT_W  saturating count of stalled valid cycles.
- clr_cnt  in  1  synchronous clear of stall_cnt.

Behaviour:
- Storage:
  - Main register M drives the outputs directly: out_valid = M.valid.
  - Skid register S has the same fields plus its own valid bit.
  - in_ready = !S.valid. It is taken from a flop, so there is no combinational path from out_ready or stall to in_ready.
- Definitions:
  - in_fire = in_valid & in_ready
  - take = out_valid & out_ready & !stall
- Reset (rst_n low, asynchronous):
  - M.valid = 0, S.valid = 0, so in_ready = 1.
  - out_pc = RESET_PC, out_ir = NOP_IR, out_ctrl = 0, stall_cnt = 0.
  - Reset asserted mid-transfer discards all held beats.
- Normal update, no flush. Rows are evaluated in order; the first match wins.
  - M empty, or take: M ← S if S.valid (then S.valid ← 0); else M ← in if in_fire; else M.valid ← 0 with M data fields unchanged.
  - M full and !take and in_fire: S ← in, S.valid ← 1.
  - Otherwise: hold.
- Latency and throughput:
  - One cycle from in_fire into an empty stage to out_valid.
  - Sustained throughput is 1 beat/cycle while out_ready=1 and stall=0.
  - Order is preserved: M drains before S, and S before new input.
- Full condition:
  - M and S both valid means in_ready=0 on the next cycle.
  - in_ready stays low until the first take after that, then returns high one cycle later.
  - The upstream must hold in_valid and data while in_ready=0.
- stall:
  - Equivalent to out_ready=0 for the transfer decision.
  - Upstream acceptance still proceeds into S while S is empty.
- flush, which overrides stall and the handshake:
  - Next edge: M.valid ← 0, S.valid ← 0, out_ir ← NOP_IR, out_ctrl ← 0; out_pc unchanged.
  - An in_fire in the flush cycle is dropped.
  - in_ready = 1 on the following cycle.
- flush with stall in the same cycle: flush wins.
- flush with a take in the same cycle: the take completes downstream (the beat is consumed) and the stage still empties.
- Invalid outputs: out_pc, out_ir and out_ctrl are don't-care while out_valid=0, except after reset/flush, where they hold the values listed above.
- stall_cnt:
  - Increments when M.valid & stall and the count is not all-ones.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt clears it to 0 and has priority over increment.
  - flush does not affect it.

Test Plan:
- Reset then idle: rst_n pulsed low mid-cycle -> out_valid=0, in_ready=1, out_ir=32'h83FFF800, out_pc=0, stall_cnt=0, all immediately (asynchronous).
- Streaming: in_valid=1 with PC 0,4,8,12 on consecutive cycles, out_ready=1 -> out_pc 0,4,8,12 one cycle later, no gaps, in_ready constantly 1.
- Skid fill: out_ready=0 from cycle 2 while PCs 0,4,8 are offered:
  - PC 0 is held in M, PC 4 is captured in S, in_ready=0 from cycle 3, and PC 8 is held upstream.
  - Raising out_ready delivers 0,4,8 in order with no loss or duplicate.
- Stall count: stall=1 for 5 cycles with M valid -> out_pc constant and stall_cnt=5. With CNT_W=3 and 10 stalled cycles -> stall_cnt=7 (saturated). clr_cnt=1 -> 0.
- Flush with full skid: M and S valid, flush=1 together with stall=1 and in_valid=1 -> next cycle out_valid=0, out_ir=NOP_IR, in_ready=1, and the offered beat never appears at the output.
- Reset mid-operation: rst_n low while M and S are valid -> both are discarded. After release, the first new beat appears with 1-cycle latency.
